// File: rtl/cmos_gate_bist_pkg.sv
// Shared types and constants for the CMOS gate BIST engine: FSM states, LFSR taps,
// fail_mask bit positions and the golden gate model.
package cmos_gate_bist_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_APPLY  = 3'd1,
      ST_SETTLE = 3'd2,
      ST_CHECK  = 3'd3,
      ST_DONE   = 3'd4
   } state_t;

   localparam int LFSR_W = 16;
   localparam int TAP_A  = 15;
   localparam int TAP_B  = 13;
   localparam int TAP_C  = 12;
   localparam int TAP_D  = 10;

   localparam int GATE_N    = 6;
   localparam int MASK_INV  = 0;
   localparam int MASK_NAND = 1;
   localparam int MASK_NOR  = 2;
   localparam int MASK_XOR  = 3;
   localparam int MASK_XNOR = 4;
   localparam int MASK_COUT = 5;

   // Expected responses for stimulus {in,a,b,cin}, packed in fail_mask bit order.
   function automatic logic [GATE_N-1:0] golden(input logic [3:0] v);
      logic in_b, a, b, cin;
      logic [GATE_N-1:0] r;
      in_b = v[3];
      a    = v[2];
      b    = v[1];
      cin  = v[0];
      r            = '0;
      r[MASK_INV]  = ~in_b;
      r[MASK_NAND] = ~(a & b);
      r[MASK_NOR]  = ~(a | b);
      r[MASK_XOR]  = a ^ b;
      r[MASK_XNOR] = ~(a ^ b);
      r[MASK_COUT] = (a & b) | (a & cin) | (b & cin);
      return r;
   endfunction

endpackage

// File: rtl/cmos_gate_bist_if.sv
// Bundle between the BIST engine and the gate harness / controller.
// Handshake: start is a level request sampled only while the engine is idle; busy
// covers the run; done is a one-cycle completion pulse with pass/err_count/fail_*
// valid from that cycle until the next accepted start.
interface cmos_gate_bist_if;
   logic       start;
   logic       busy;
   logic       done;
   logic       pass;
   logic       stim_in;
   logic       stim_a;
   logic       stim_b;
   logic       stim_cin;
   logic       rsp_inv;
   logic       rsp_nand;
   logic       rsp_nor;
   logic       rsp_xor;
   logic       rsp_xnor;
   logic       rsp_cout;
   logic [7:0] err_count;
   logic [7:0] fail_idx;
   logic [3:0] fail_vec;
   logic [5:0] fail_mask;

   modport master (
      output start, rsp_inv, rsp_nand, rsp_nor, rsp_xor, rsp_xnor, rsp_cout,
      input  busy, done, pass, stim_in, stim_a, stim_b, stim_cin,
      input  err_count, fail_idx, fail_vec, fail_mask
   );

   modport slave (
      input  start, rsp_inv, rsp_nand, rsp_nor, rsp_xor, rsp_xnor, rsp_cout,
      output busy, done, pass, stim_in, stim_a, stim_b, stim_cin,
      output err_count, fail_idx, fail_vec, fail_mask
   );
endinterface

// File: rtl/bist_lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) with synchronous seed load and
// single-step advance; shared by BIST blocks that need a repeatable sequence.
module bist_lfsr16
   import cmos_gate_bist_pkg::*;
#(
   parameter logic [LFSR_W-1:0] RST_VAL = 16'hACE1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [LFSR_W-1:0] seed,
   input  logic              advance,
   output logic [LFSR_W-1:0] q
);

   logic fb;

   assign fb = q[TAP_A] ^ q[TAP_B] ^ q[TAP_C] ^ q[TAP_D];

   // load wins over advance so a restart always begins from the seed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= RST_VAL;
      end else if (load) begin
         q <= seed;
      end else if (advance) begin
         q <= {q[LFSR_W-2:0], fb};
      end
   end

endmodule

// File: rtl/cmos_gate_bist.sv
// BIST engine for the switch-level CMOS gate library: drives LFSR stimulus, waits
// for settling, checks six gate responses and records the first failing vector.
module cmos_gate_bist
   import cmos_gate_bist_pkg::*;
#(
   parameter int              NUM_VECTORS   = 10,
   parameter int              SETTLE_CYCLES = 2,
   parameter logic [LFSR_W-1:0] LFSR_SEED   = 16'hACE1
) (
   input  logic   clk,
   input  logic   rst_n,
   cmos_gate_bist_if.slave bus,
   output state_t dbg_state
);

   localparam logic [7:0] LAST_CNT   = 8'(NUM_VECTORS);
   localparam logic [3:0] SETTLE_INI = 4'(SETTLE_CYCLES - 1);

   state_t              state;
   state_t              state_nxt;
   logic                lfsr_load;
   logic                lfsr_adv;
   logic [LFSR_W-1:0]   lfsr_q;
   logic                unused_lfsr;

   logic [3:0]          stim;
   logic [3:0]          settle_cnt;
   logic [7:0]          vec_cnt;
   logic [7:0]          vec_cnt_inc;
   logic                last_vec;
   logic [7:0]          err_count;
   logic [7:0]          err_inc;
   logic [7:0]          fail_idx;
   logic [3:0]          fail_vec;
   logic [GATE_N-1:0]   fail_mask;
   logic                pass;

   logic [GATE_N-1:0]   rsp_vec;
   logic [GATE_N-1:0]   exp_vec;
   logic [GATE_N-1:0]   mism;
   logic                any_mism;

   bist_lfsr16 #(
      .RST_VAL (LFSR_SEED)
   ) u_lfsr (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (lfsr_load),
      .seed    (LFSR_SEED),
      .advance (lfsr_adv),
      .q       (lfsr_q)
   );

   assign unused_lfsr = ^lfsr_q[LFSR_W-1:4];

   // ---------------- FSM ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      lfsr_load = 1'b0;
      lfsr_adv  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (bus.start) begin
               lfsr_load = 1'b1;
               state_nxt = ST_APPLY;
            end
         end
         ST_APPLY: begin
            lfsr_adv  = 1'b1;
            state_nxt = ST_SETTLE;
         end
         ST_SETTLE: begin
            if (settle_cnt == 4'd0) begin
               state_nxt = ST_CHECK;
            end
         end
         ST_CHECK: begin
            state_nxt = last_vec ? ST_DONE : ST_APPLY;
         end
         ST_DONE: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // ---------------- Response compare ----------------
   assign rsp_vec = {bus.rsp_cout, bus.rsp_xnor, bus.rsp_xor,
                     bus.rsp_nor, bus.rsp_nand, bus.rsp_inv};
   assign exp_vec = golden(stim);

   // Case inequality makes an undriven or X response count as a failure in simulation.
   always_comb begin
      mism = '0;
      for (int i = 0; i < GATE_N; i++) begin
         mism[i] = (rsp_vec[i] !== exp_vec[i]);
      end
   end

   assign any_mism    = |mism;
   assign vec_cnt_inc = vec_cnt + 8'd1;
   assign last_vec    = (vec_cnt_inc == LAST_CNT);
   assign err_inc     = (err_count == 8'hFF) ? err_count : err_count + 8'd1;

   // ---------------- Datapath ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stim       <= '0;
         settle_cnt <= '0;
         vec_cnt    <= '0;
         err_count  <= '0;
         fail_idx   <= '0;
         fail_vec   <= '0;
         fail_mask  <= '0;
         pass       <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.start) begin
                  vec_cnt   <= '0;
                  err_count <= '0;
                  fail_idx  <= '0;
                  fail_vec  <= '0;
                  fail_mask <= '0;
                  pass      <= 1'b0;
               end
            end
            ST_APPLY: begin
               stim       <= lfsr_q[3:0];
               settle_cnt <= SETTLE_INI;
            end
            ST_SETTLE: begin
               if (settle_cnt != 4'd0) begin
                  settle_cnt <= settle_cnt - 4'd1;
               end
            end
            ST_CHECK: begin
               if (any_mism) begin
                  err_count <= err_inc;
                  // err_count never wraps, so zero means no earlier failure this run.
                  if (err_count == 8'd0) begin
                     fail_idx  <= vec_cnt;
                     fail_vec  <= stim;
                     fail_mask <= mism;
                  end
               end
               vec_cnt <= vec_cnt_inc;
               if (last_vec) begin
                  pass <= !any_mism && (err_count == 8'd0);
               end
            end
            default: begin
            end
         endcase
      end
   end

   // ---------------- Outputs ----------------
   assign bus.busy      = (state == ST_APPLY) || (state == ST_SETTLE) || (state == ST_CHECK);
   assign bus.done      = (state == ST_DONE);
   assign bus.pass      = pass;
   assign bus.stim_in   = stim[3];
   assign bus.stim_a    = stim[2];
   assign bus.stim_b    = stim[1];
   assign bus.stim_cin  = stim[0];
   assign bus.err_count = err_count;
   assign bus.fail_idx  = fail_idx;
   assign bus.fail_vec  = fail_vec;
   assign bus.fail_mask = fail_mask;
   assign dbg_state     = state;

endmodule
